// File: rtl/lrn_pkg.sv
// Shared types for the LRN address generator: sequencer states and traversal-order encoding.
package lrn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } lrn_state_e;

  localparam logic MODE_CH_INNER  = 1'b0;
  localparam logic MODE_ROW_MAJOR = 1'b1;

endpackage

// File: rtl/lrn_addr_gen_if.sv
// GLB read port and divider write-back port of the LRN address generator.
// Handshakes: a read transfers on an edge where r_enable && r_ready; once raised, r_enable/r_addr
// hold until that edge. w_enable is a one-cycle strobe with no back-pressure; div_out_valid is a pulse.
interface lrn_addr_gen_if #(
  parameter int ADDR_BUS_WIDTH = 20
);
  logic                      r_enable;
  logic [ADDR_BUS_WIDTH-1:0] r_addr;
  logic                      r_ready;
  logic                      full_flag;
  logic                      div_out_valid;
  logic                      w_enable;
  logic [ADDR_BUS_WIDTH-1:0] w_addr;

  modport master (
    output r_enable, r_addr, w_enable, w_addr,
    input  r_ready, full_flag, div_out_valid
  );

  modport slave (
    input  r_enable, r_addr, w_enable, w_addr,
    output r_ready, full_flag, div_out_valid
  );
endinterface

// File: rtl/lrn_index_counter.sv
// Four-level nested wrap counter over (n,m,e,f); mode picks which index is innermost.
module lrn_index_counter
  import lrn_pkg::*;
#(
  parameter int N_WIDTH = 2,
  parameter int M_WIDTH = 10,
  parameter int E_WIDTH = 6,
  parameter int F_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  input  logic               mode,
  input  logic [N_WIDTH-1:0] lim_n,
  input  logic [M_WIDTH-1:0] lim_m,
  input  logic [E_WIDTH-1:0] lim_e,
  input  logic [F_WIDTH-1:0] lim_f,
  output logic [N_WIDTH-1:0] idx_n,
  output logic [M_WIDTH-1:0] idx_m,
  output logic [E_WIDTH-1:0] idx_e,
  output logic [F_WIDTH-1:0] idx_f,
  output logic               last
);

  logic [N_WIDTH-1:0] n_q, n_d;
  logic [M_WIDTH-1:0] m_q, m_d;
  logic [E_WIDTH-1:0] e_q, e_d;
  logic [F_WIDTH-1:0] f_q, f_d;
  logic               at_n, at_m, at_e, at_f;

  assign at_n = (n_q == lim_n - N_WIDTH'(1));
  assign at_m = (m_q == lim_m - M_WIDTH'(1));
  assign at_e = (e_q == lim_e - E_WIDTH'(1));
  assign at_f = (f_q == lim_f - F_WIDTH'(1));
  assign last = at_n & at_m & at_e & at_f;

  always_comb begin
    n_d = n_q;
    m_d = m_q;
    e_d = e_q;
    f_d = f_q;
    if (adv) begin
      if (mode == MODE_CH_INNER) begin
        // m innermost, then f, then e, n outermost
        m_d = at_m ? '0 : m_q + M_WIDTH'(1);
        if (at_m) begin
          f_d = at_f ? '0 : f_q + F_WIDTH'(1);
          if (at_f) begin
            e_d = at_e ? '0 : e_q + E_WIDTH'(1);
            if (at_e) n_d = at_n ? '0 : n_q + N_WIDTH'(1);
          end
        end
      end else begin
        f_d = at_f ? '0 : f_q + F_WIDTH'(1);
        if (at_f) begin
          e_d = at_e ? '0 : e_q + E_WIDTH'(1);
          if (at_e) begin
            m_d = at_m ? '0 : m_q + M_WIDTH'(1);
            if (at_m) n_d = at_n ? '0 : n_q + N_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      n_q <= '0;
      m_q <= '0;
      e_q <= '0;
      f_q <= '0;
    end else begin
      n_q <= n_d;
      m_q <= m_d;
      e_q <= e_d;
      f_q <= f_d;
    end
  end

  assign idx_n = n_q;
  assign idx_m = m_q;
  assign idx_e = e_q;
  assign idx_f = f_q;

endmodule

// File: rtl/lrn_addr_gen.sv
// LRN layer sequencer: streams input pixels from the GLB under an inflight credit limit and
// writes divider results into a padded output tensor in the same traversal order.
module lrn_addr_gen
  import lrn_pkg::*;
#(
  parameter int N_WIDTH        = 2,
  parameter int M_WIDTH        = 10,
  parameter int E_WIDTH        = 6,
  parameter int F_WIDTH        = 6,
  parameter int V_WIDTH        = 2,
  parameter int ADDR_BUS_WIDTH = 20,
  parameter int MAX_INFLIGHT   = 8
) (
  input  logic                      core_clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [N_WIDTH-1:0]        dim4,
  input  logic [M_WIDTH-1:0]        dim3,
  input  logic [E_WIDTH-1:0]        dim2,
  input  logic [F_WIDTH-1:0]        dim1,
  input  logic [V_WIDTH-1:0]        padding_num,
  input  logic                      mode,
  input  logic [ADDR_BUS_WIDTH-1:0] rd_base,
  input  logic [ADDR_BUS_WIDTH-1:0] wr_base,
  lrn_addr_gen_if.master            bus,
  output logic                      layer_done,
  output logic                      busy,
  output logic                      err,
  output lrn_state_e                dbg_state
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int CW = N_WIDTH + M_WIDTH + E_WIDTH + F_WIDTH;
  localparam int PW = CW + ADDR_BUS_WIDTH + 8;
  typedef logic [PW-1:0] prod_t;

  lrn_state_e                state_q, state_d;
  logic [N_WIDTH-1:0]        dim4_q, dim4_d;
  logic [M_WIDTH-1:0]        dim3_q, dim3_d;
  logic [E_WIDTH-1:0]        dim2_q, dim2_d;
  logic [F_WIDTH-1:0]        dim1_q, dim1_d;
  logic [V_WIDTH-1:0]        pad_q, pad_d;
  logic                      mode_q, mode_d;
  logic [ADDR_BUS_WIDTH-1:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;
  logic [IW-1:0]             inflight_q, inflight_d;
  logic [CW-1:0]             wr_cnt_q, wr_cnt_d;
  logic                      rd_all_q, rd_all_d;
  logic                      r_enable_q, r_enable_d;
  logic [ADDR_BUS_WIDTH-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic                      w_enable_q, w_enable_d;
  logic                      layer_done_q, layer_done_d;
  logic                      err_q, err_d;

  logic                      acc, wr_ok, rd_adv, cfg_clr, rd_last, wr_last;
  logic [N_WIDTH-1:0]        rd_n, wr_n;
  logic [M_WIDTH-1:0]        rd_m, wr_m;
  logic [E_WIDTH-1:0]        rd_e, wr_e;
  logic [F_WIDTH-1:0]        rd_f, wr_f;
  logic [E_WIDTH:0]          p2;
  logic [F_WIDTH:0]          p1;
  prod_t                     rd_lin, wr_lin;
  logic [CW-1:0]             total;

  lrn_index_counter #(.N_WIDTH(N_WIDTH), .M_WIDTH(M_WIDTH), .E_WIDTH(E_WIDTH), .F_WIDTH(F_WIDTH)) u_rd_cnt (
    .clk(core_clk), .rst_n(reset_n), .clr(cfg_clr), .adv(rd_adv), .mode(mode_q),
    .lim_n(dim4_q), .lim_m(dim3_q), .lim_e(dim2_q), .lim_f(dim1_q),
    .idx_n(rd_n), .idx_m(rd_m), .idx_e(rd_e), .idx_f(rd_f), .last(rd_last)
  );

  lrn_index_counter #(.N_WIDTH(N_WIDTH), .M_WIDTH(M_WIDTH), .E_WIDTH(E_WIDTH), .F_WIDTH(F_WIDTH)) u_wr_cnt (
    .clk(core_clk), .rst_n(reset_n), .clr(cfg_clr), .adv(wr_ok), .mode(mode_q),
    .lim_n(dim4_q), .lim_m(dim3_q), .lim_e(dim2_q), .lim_f(dim1_q),
    .idx_n(wr_n), .idx_m(wr_m), .idx_e(wr_e), .idx_f(wr_f), .last(wr_last)
  );

  // Padded extents; one extra bit so dim + 2*pad never wraps.
  assign p2 = {1'b0, dim2_q} + (E_WIDTH+1)'({pad_q, 1'b0});
  assign p1 = {1'b0, dim1_q} + (F_WIDTH+1)'({pad_q, 1'b0});

  assign rd_lin = ((prod_t'(rd_n) * prod_t'(dim3_q) + prod_t'(rd_m)) * prod_t'(dim2_q) + prod_t'(rd_e))
                  * prod_t'(dim1_q) + prod_t'(rd_f) + prod_t'(rd_base_q);
  assign wr_lin = ((prod_t'(wr_n) * prod_t'(dim3_q) + prod_t'(wr_m)) * prod_t'(p2) + prod_t'(wr_e) + prod_t'(pad_q))
                  * prod_t'(p1) + prod_t'(wr_f) + prod_t'(pad_q) + prod_t'(wr_base_q);
  assign total  = CW'(dim1_q) * CW'(dim2_q) * CW'(dim3_q) * CW'(dim4_q);

  always_comb begin
    state_d      = state_q;
    dim4_d       = dim4_q;
    dim3_d       = dim3_q;
    dim2_d       = dim2_q;
    dim1_d       = dim1_q;
    pad_d        = pad_q;
    mode_d       = mode_q;
    rd_base_d    = rd_base_q;
    wr_base_d    = wr_base_q;
    rd_all_d     = rd_all_q;
    r_enable_d   = r_enable_q;
    r_addr_d     = r_addr_q;
    w_enable_d   = 1'b0;
    w_addr_d     = w_addr_q;
    layer_done_d = 1'b0;
    err_d        = err_q;
    cfg_clr      = 1'b0;
    rd_adv       = 1'b0;
    acc          = r_enable_q & bus.r_ready;
    wr_ok        = bus.div_out_valid && (inflight_q != '0) && (state_q == S_RUN || state_q == S_DRAIN);
    inflight_d   = inflight_q + IW'(acc) - IW'(wr_ok);
    wr_cnt_d     = wr_cnt_q + CW'(wr_ok);

    if (wr_ok) begin
      w_enable_d = 1'b1;
      w_addr_d   = wr_lin[ADDR_BUS_WIDTH-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dim4_d     = dim4;
          dim3_d     = dim3;
          dim2_d     = dim2;
          dim1_d     = dim1;
          pad_d      = padding_num;
          mode_d     = mode;
          rd_base_d  = rd_base;
          wr_base_d  = wr_base;
          cfg_clr    = 1'b1;
          inflight_d = '0;
          wr_cnt_d   = '0;
          rd_all_d   = 1'b0;
          if (dim4 == '0 || dim3 == '0 || dim2 == '0 || dim1 == '0) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            err_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        // A raised request is frozen until accepted; only a free slot may raise a new one.
        if (!r_enable_q || bus.r_ready) begin
          r_enable_d = 1'b0;
          if (!rd_all_q && inflight_d < IW'(MAX_INFLIGHT) && !bus.full_flag) begin
            r_enable_d = 1'b1;
            r_addr_d   = rd_lin[ADDR_BUS_WIDTH-1:0];
            rd_adv     = 1'b1;
            rd_all_d   = rd_last;
          end
        end
        if (acc && rd_all_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_ok && wr_last && wr_cnt_d == total) state_d = S_DONE;
      end
      S_DONE: begin
        state_d      = S_IDLE;
        layer_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.div_out_valid && !wr_ok) err_d = 1'b1;
  end

  always_ff @(posedge core_clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      dim4_q       <= '0;
      dim3_q       <= '0;
      dim2_q       <= '0;
      dim1_q       <= '0;
      pad_q        <= '0;
      mode_q       <= MODE_CH_INNER;
      rd_base_q    <= '0;
      wr_base_q    <= '0;
      inflight_q   <= '0;
      wr_cnt_q     <= '0;
      rd_all_q     <= 1'b0;
      r_enable_q   <= 1'b0;
      r_addr_q     <= '0;
      w_enable_q   <= 1'b0;
      w_addr_q     <= '0;
      layer_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dim4_q       <= dim4_d;
      dim3_q       <= dim3_d;
      dim2_q       <= dim2_d;
      dim1_q       <= dim1_d;
      pad_q        <= pad_d;
      mode_q       <= mode_d;
      rd_base_q    <= rd_base_d;
      wr_base_q    <= wr_base_d;
      inflight_q   <= inflight_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_all_q     <= rd_all_d;
      r_enable_q   <= r_enable_d;
      r_addr_q     <= r_addr_d;
      w_enable_q   <= w_enable_d;
      w_addr_q     <= w_addr_d;
      layer_done_q <= layer_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.r_enable = r_enable_q;
  assign bus.r_addr   = r_addr_q;
  assign bus.w_enable = w_enable_q;
  assign bus.w_addr   = w_addr_q;
  assign layer_done   = layer_done_q;
  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_lrn_addr_gen.sv
// Directed bench for lrn_addr_gen: traversal orders, padding, credit limit, back-pressure, reset and error paths.
module tb_lrn_addr_gen;
  import lrn_pkg::*;

  localparam int AW = 20;

  logic          core_clk = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic [1:0]    dim4     = '0;
  logic [9:0]    dim3     = '0;
  logic [5:0]    dim2     = '0;
  logic [5:0]    dim1     = '0;
  logic [1:0]    padding_num = '0;
  logic          mode     = 1'b0;
  logic [AW-1:0] rd_base  = '0;
  logic [AW-1:0] wr_base  = '0;
  logic          layer_done, busy, err;
  lrn_state_e    dbg_state;

  lrn_addr_gen_if #(.ADDR_BUS_WIDTH(AW)) bus ();

  // Divider model: echoes each accepted read 3 cycles later, or manual pulses when echo is off.
  logic       echo_en    = 1'b0;
  logic       div_manual = 1'b0;
  logic       echo_v     = 1'b0;
  logic [2:0] pipe       = '0;
  assign bus.div_out_valid = echo_en ? echo_v : div_manual;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wen_cyc = 0;
  int done_cyc = 0;
  bit ren_seen = 1'b0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] rd_obs_q[$];
  logic [AW-1:0] wr_obs_q[$];

  lrn_addr_gen #(
    .N_WIDTH(2), .M_WIDTH(10), .E_WIDTH(6), .F_WIDTH(6), .V_WIDTH(2),
    .ADDR_BUS_WIDTH(AW), .MAX_INFLIGHT(4)
  ) dut (
    .core_clk(core_clk), .reset_n(reset_n), .start(start),
    .dim4(dim4), .dim3(dim3), .dim2(dim2), .dim1(dim1),
    .padding_num(padding_num), .mode(mode), .rd_base(rd_base), .wr_base(wr_base),
    .bus(bus), .layer_done(layer_done), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc++;

  // monitor + divider echo, sampled mid-cycle
  always @(negedge core_clk) begin
    if (!reset_n) begin
      pipe   = '0;
      echo_v = 1'b0;
    end else begin
      echo_v = pipe[2];
      pipe   = {pipe[1:0], bus.r_enable & bus.r_ready};
      if (bus.r_enable && bus.r_ready) rd_obs_q.push_back(bus.r_addr);
      if (bus.r_enable) ren_seen = 1'b1;
      if (bus.w_enable) begin
        wr_obs_q.push_back(bus.w_addr);
        last_wen_cyc = cyc;
      end
      if (layer_done) done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge core_clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [AW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic clear_obs();
    rd_obs_q.delete();
    wr_obs_q.delete();
    exp_q.delete();
  endtask

  // scoreboard: drains exp_q against the observed read or write stream
  task automatic check_obs(input string tag, input bit is_wr);
    int n_obs;
    logic [AW-1:0] o;
    n_obs = is_wr ? wr_obs_q.size() : rd_obs_q.size();
    check({tag, "_count"}, 32'(n_obs), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      o = '1;
      if (is_wr) begin
        if (wr_obs_q.size() > 0) o = wr_obs_q.pop_front();
      end else begin
        if (rd_obs_q.size() > 0) o = rd_obs_q.pop_front();
      end
      check(tag, 32'(o), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic start_layer(input logic [1:0] d4, input logic [9:0] d3, input logic [5:0] d2,
                             input logic [5:0] d1, input logic [1:0] p, input logic md,
                             input logic [AW-1:0] rb, input logic [AW-1:0] wb);
    dim4 = d4; dim3 = d3; dim2 = d2; dim1 = d1;
    padding_num = p; mode = md; rd_base = rb; wr_base = wb;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!layer_done && n < 400) begin
      step(1);
      n++;
    end
    check({tag, "_layer_done"}, 32'(layer_done), 32'd1);
  endtask

  initial begin
    bus.r_ready   = 1'b1;
    bus.full_flag = 1'b0;

    // reset state
    step(2);
    check("rst_r_enable", 32'(bus.r_enable), 32'd0);
    check("rst_r_addr", 32'(bus.r_addr), 32'd0);
    check("rst_w_enable", 32'(bus.w_enable), 32'd0);
    check("rst_w_addr", 32'(bus.w_addr), 32'd0);
    check("rst_layer_done", 32'(layer_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset_n = 1'b1;
    step(1);

    // channel-innermost full layer, divider echoes after 3 cycles
    clear_obs();
    echo_en = 1'b1;
    start_layer(2'd1, 10'd2, 6'd2, 6'd2, 2'd0, MODE_CH_INNER, 20'd0, 20'd0);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_r_enable_not_yet", 32'(bus.r_enable), 32'd0);
    step(1);
    check("t1_r_enable_first", 32'(bus.r_enable), 32'd1);
    check("t1_r_addr_first", 32'(bus.r_addr), 32'd0);
    wait_done("t1");
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    step(1);
    check("t1_done_pulse_width", 32'(layer_done), 32'd0);
    check("t1_done_after_last_w", 32'(done_cyc - last_wen_cyc), 32'd1);
    push(20'd0); push(20'd4); push(20'd1); push(20'd5);
    push(20'd2); push(20'd6); push(20'd3); push(20'd7);
    check_obs("t1_r_addr", 1'b0);
    push(20'd0); push(20'd4); push(20'd1); push(20'd5);
    push(20'd2); push(20'd6); push(20'd3); push(20'd7);
    check_obs("t1_w_addr", 1'b1);

    // row-major with padding 1 into a base of 100
    clear_obs();
    start_layer(2'd1, 10'd1, 6'd2, 6'd2, 2'd1, MODE_ROW_MAJOR, 20'd0, 20'd100);
    wait_done("t2");
    check("t2_err", 32'(err), 32'd0);
    push(20'd0); push(20'd1); push(20'd2); push(20'd3);
    check_obs("t2_r_addr", 1'b0);
    push(20'd105); push(20'd106); push(20'd109); push(20'd110);
    check_obs("t2_w_addr", 1'b1);
    step(2);

    // credit limit with a manually driven divider
    clear_obs();
    echo_en = 1'b0;
    start_layer(2'd1, 10'd1, 6'd4, 6'd4, 2'd0, MODE_CH_INNER, 20'd0, 20'd0);
    step(10);
    check("t3_reads_at_limit", 32'(rd_obs_q.size()), 32'd4);
    check("t3_r_enable_blocked", 32'(bus.r_enable), 32'd0);
    div_manual = 1'b1; step(1); div_manual = 1'b0;
    step(5);
    check("t3_reads_after_one_credit", 32'(rd_obs_q.size()), 32'd5);
    check("t3_writes_after_one_credit", 32'(wr_obs_q.size()), 32'd1);
    bus.r_ready = 1'b0;
    div_manual = 1'b1; step(1); div_manual = 1'b0;
    step(3);
    check("t3_pending_r_enable", 32'(bus.r_enable), 32'd1);
    check("t3_pending_r_addr", 32'(bus.r_addr), 32'd5);
    bus.r_ready = 1'b1;
    div_manual = 1'b1; step(1); div_manual = 1'b0;
    step(5);
    push(20'd0); push(20'd1); push(20'd2); push(20'd3);
    push(20'd4); push(20'd5); push(20'd6);
    check_obs("t3_r_addr_simul", 1'b0);
    push(20'd0); push(20'd1); push(20'd2);
    check_obs("t3_w_addr", 1'b1);

    // reset while a layer is still running
    check("t3_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step(1);
    check("mid_rst_r_enable", 32'(bus.r_enable), 32'd0);
    check("mid_rst_r_addr", 32'(bus.r_addr), 32'd0);
    check("mid_rst_w_addr", 32'(bus.w_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset_n = 1'b1;
    step(1);

    // back-pressure and full_flag on a fresh layer
    clear_obs();
    echo_en = 1'b1;
    start_layer(2'd1, 10'd1, 6'd4, 6'd4, 2'd0, MODE_CH_INNER, 20'd0, 20'd0);
    begin
      int n;
      n = 0;
      while (rd_obs_q.size() < 3 && n < 50) begin
        step(1);
        n++;
      end
    end
    check("t4_three_reads", 32'(rd_obs_q.size()), 32'd3);
    bus.r_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (i == 2) bus.full_flag = 1'b1;
      check("t4_hold_r_enable", 32'(bus.r_enable), 32'd1);
      check("t4_hold_r_addr", 32'(bus.r_addr), 32'd3);
    end
    bus.r_ready = 1'b1;
    step(1);
    check("t4_full_blocks_new", 32'(bus.r_enable), 32'd0);
    step(2);
    check("t4_full_still_blocks", 32'(bus.r_enable), 32'd0);
    bus.full_flag = 1'b0;
    step(1);
    check("t4_resume_r_enable", 32'(bus.r_enable), 32'd1);
    check("t4_resume_r_addr", 32'(bus.r_addr), 32'd4);
    wait_done("t4");
    check("t4_err", 32'(err), 32'd0);
    for (int i = 0; i < 16; i++) push(AW'(i));
    check_obs("t4_r_addr", 1'b0);
    for (int i = 0; i < 16; i++) push(AW'(i));
    check_obs("t4_w_addr", 1'b1);
    step(2);

    // zero dimension: immediate DONE with err, no reads
    clear_obs();
    ren_seen = 1'b0;
    start_layer(2'd1, 10'd0, 6'd2, 6'd2, 2'd0, MODE_CH_INNER, 20'd0, 20'd0);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_no_done_yet", 32'(layer_done), 32'd0);
    step(1);
    check("t5_layer_done", 32'(layer_done), 32'd1);
    check("t5_busy_low", 32'(busy), 32'd0);
    step(1);
    check("t5_done_one_cycle", 32'(layer_done), 32'd0);
    step(3);
    check("t5_no_r_enable", 32'(ren_seen), 32'd0);

    // accepted start clears err
    start_layer(2'd1, 10'd1, 6'd1, 6'd1, 2'd0, MODE_CH_INNER, 20'd0, 20'd0);
    check("t6_err_cleared", 32'(err), 32'd0);
    wait_done("t6");
    step(2);

    // stray divider output in IDLE
    clear_obs();
    echo_en = 1'b0;
    div_manual = 1'b1; step(1); div_manual = 1'b0;
    check("t7_err_idle_div", 32'(err), 32'd1);
    step(2);
    check("t7_no_w_enable", 32'(wr_obs_q.size()), 32'd0);
    check("t7_state_idle", 32'(dbg_state), 32'(S_IDLE));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
